// File: rtl/rollback_seq.sv
// Rollback sequencer: arbitrates exe/com redirect requests, walks the in-flight opid
// window youngest-first emitting rollback beats, then pulses one redirect to fetch.
module rollback_seq #(
  parameter int RW  = 2,
  parameter int IDW = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     exe_req,
  input  logic [IDW:0]             exe_opid,
  input  logic [63:0]              exe_npc,
  input  logic                     com_req,
  input  logic [IDW:0]             com_opid,
  input  logic [63:0]              com_npc,
  input  logic [IDW-1:0]           head_opid,
  input  logic [IDW-1:0]           tail_opid,
  input  logic                     rb_ready,
  output logic [RW-1:0]            rb_valid,
  output logic [RW-1:0][IDW-1:0]   rb_opid,
  output logic                     red_valid,
  output logic [63:0]              red_npc,
  output logic [IDW:0]             red_opid,
  output logic                     busy
);

  typedef enum logic [1:0] {S_IDLE, S_WALK, S_REDIR} state_t;

  localparam logic [IDW-1:0] RW_W = IDW'(RW);

  state_t         r_state;
  logic [IDW-1:0] r_wp;
  logic [IDW-1:0] r_tgt;
  logic [63:0]    r_npc;
  logic [IDW:0]   r_opid;
  logic           r_incl;

  logic [IDW-1:0] w_inflight;
  logic [IDW-1:0] w_exe_age;
  logic [IDW-1:0] w_com_age;
  logic           w_exe_ok;
  logic           w_com_ok;
  logic           w_pick_com;
  logic           w_req_ok;
  logic [IDW:0]   w_req_opid;
  logic [IDW-1:0] w_req_tgt;
  logic [63:0]    w_req_npc;
  logic           w_req_incl;
  logic [IDW-1:0] w_req_age;
  logic [IDW-1:0] w_tgt_age;
  logic           w_older;
  logic           w_retgt;
  logic [IDW-1:0] w_rem;
  logic [IDW-1:0] w_emit;
  logic [IDW-1:0] w_wp_beat;
  logic [IDW-1:0] w_new_tgt;
  logic           w_new_incl;
  logic [IDW-1:0] w_rem_next;
  logic [IDW-1:0] w_acc_wp;
  logic [IDW-1:0] w_acc_rem;

  // Ages are measured from head so that ordering survives opid wrap-around.
  assign w_inflight = tail_opid - head_opid;
  assign w_exe_age  = exe_opid[IDW-1:0] - head_opid;
  assign w_com_age  = com_opid[IDW-1:0] - head_opid;
  assign w_exe_ok   = exe_req && exe_opid[IDW] && (w_exe_age < w_inflight);
  assign w_com_ok   = com_req && com_opid[IDW] && (w_com_age < w_inflight);
  assign w_pick_com = w_com_ok && (!w_exe_ok || (w_com_age <= w_exe_age));
  assign w_req_ok   = w_exe_ok || w_com_ok;

  assign w_req_opid = w_pick_com ? com_opid : exe_opid;
  assign w_req_npc  = w_pick_com ? com_npc  : exe_npc;
  assign w_req_incl = w_pick_com;
  assign w_req_tgt  = w_req_opid[IDW-1:0];
  assign w_req_age  = w_pick_com ? w_com_age : w_exe_age;
  assign w_tgt_age  = r_tgt - head_opid;
  assign w_older    = w_req_ok && (w_req_age < w_tgt_age);
  assign w_retgt    = (r_state != S_IDLE) && w_older;

  // Remaining entries: wp down to just above the target (exclusive) or to the
  // target itself (inclusive). Reaches exactly 0 when the walk completes.
  assign w_rem      = r_wp - r_tgt + IDW'(r_incl);
  assign w_emit     = (w_rem > RW_W) ? RW_W : w_rem;
  assign w_wp_beat  = (r_state == S_WALK && rb_ready) ? (r_wp - w_emit) : r_wp;
  assign w_new_tgt  = w_retgt ? w_req_tgt  : r_tgt;
  assign w_new_incl = w_retgt ? w_req_incl : r_incl;
  assign w_rem_next = w_wp_beat - w_new_tgt + IDW'(w_new_incl);

  assign w_acc_wp   = tail_opid - IDW'(1);
  assign w_acc_rem  = w_acc_wp - w_req_tgt + IDW'(w_req_incl);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wp    <= '0;
      r_tgt   <= '0;
      r_npc   <= '0;
      r_opid  <= '0;
      r_incl  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req_ok) begin
            r_tgt   <= w_req_tgt;
            r_npc   <= w_req_npc;
            r_opid  <= w_req_opid;
            r_incl  <= w_req_incl;
            r_wp    <= w_acc_wp;
            r_state <= (w_acc_rem == '0) ? S_REDIR : S_WALK;
          end
        end
        S_WALK, S_REDIR: begin
          r_wp <= w_wp_beat;
          if (w_retgt) begin
            r_tgt  <= w_req_tgt;
            r_npc  <= w_req_npc;
            r_opid <= w_req_opid;
            r_incl <= w_req_incl;
          end
          // A REDIR cycle without a retarget has delivered its pulse.
          if (w_retgt || r_state == S_WALK)
            r_state <= (w_rem_next == '0) ? S_REDIR : S_WALK;
          else
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < RW; gi++) begin : g_lane
      assign rb_valid[gi] = (r_state == S_WALK) && (IDW'(gi) < w_emit);
      assign rb_opid[gi]  = rb_valid[gi] ? (r_wp - IDW'(gi)) : '0;
    end
  endgenerate

  assign red_valid = (r_state == S_REDIR) && !w_retgt;
  assign red_npc   = r_npc;
  assign red_opid  = r_opid;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_rollback_seq.sv
// Directed bench for rollback_seq (RW=2, IDW=15): inputs driven at the falling edge,
// outputs checked 1ns later, each expectation worked out by hand.
module tb_rollback_seq;

  logic              clk;
  logic              rst;
  logic              exe_req;
  logic [15:0]       exe_opid;
  logic [63:0]       exe_npc;
  logic              com_req;
  logic [15:0]       com_opid;
  logic [63:0]       com_npc;
  logic [14:0]       head_opid;
  logic [14:0]       tail_opid;
  logic              rb_ready;
  logic [1:0]        rb_valid;
  logic [1:0][14:0]  rb_opid;
  logic              red_valid;
  logic [63:0]       red_npc;
  logic [15:0]       red_opid;
  logic              busy;

  int n_pass  = 0;
  int n_total = 0;

  rollback_seq #(.RW(2), .IDW(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .exe_req   (exe_req),
    .exe_opid  (exe_opid),
    .exe_npc   (exe_npc),
    .com_req   (com_req),
    .com_opid  (com_opid),
    .com_npc   (com_npc),
    .head_opid (head_opid),
    .tail_opid (tail_opid),
    .rb_ready  (rb_ready),
    .rb_valid  (rb_valid),
    .rb_opid   (rb_opid),
    .red_valid (red_valid),
    .red_npc   (red_npc),
    .red_opid  (red_opid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
    exe_req = 1'b0;
    com_req = 1'b0;
  endtask

  task automatic beat(input string tag, input logic [1:0] v, input logic [14:0] o0, input logic [14:0] o1);
    chk({tag, ".rb_valid"}, 64'(rb_valid), 64'(v));
    if (v[0]) chk({tag, ".lane0"}, 64'(rb_opid[0]), 64'(o0));
    if (v[1]) chk({tag, ".lane1"}, 64'(rb_opid[1]), 64'(o1));
    chk({tag, ".red_valid"}, 64'(red_valid), 64'(0));
    chk({tag, ".busy"}, 64'(busy), 64'(1));
    $display("beat %s rb_valid=%b lane0=%h lane1=%h", tag, rb_valid, rb_opid[0], rb_opid[1]);
  endtask

  task automatic redir(input string tag, input logic [15:0] op, input logic [63:0] npc);
    chk({tag, ".rb_valid"}, 64'(rb_valid), 64'(0));
    chk({tag, ".red_valid"}, 64'(red_valid), 64'(1));
    chk({tag, ".red_opid"}, 64'(red_opid), 64'(op));
    chk({tag, ".red_npc"}, red_npc, npc);
    chk({tag, ".busy"}, 64'(busy), 64'(1));
    $display("redir %s red_opid=%h red_npc=%h", tag, red_opid, red_npc);
  endtask

  task automatic idle(input string tag);
    chk({tag, ".busy"}, 64'(busy), 64'(0));
    chk({tag, ".rb_valid"}, 64'(rb_valid), 64'(0));
    chk({tag, ".red_valid"}, 64'(red_valid), 64'(0));
    $display("idle %s busy=%b", tag, busy);
  endtask

  initial begin
    rst = 1'b1; exe_req = 1'b0; exe_opid = '0; exe_npc = '0;
    com_req = 1'b0; com_opid = '0; com_npc = '0;
    head_opid = '0; tail_opid = '0; rb_ready = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    idle("reset");
    chk("reset.red_npc", red_npc, 64'h0);
    chk("reset.red_opid", 64'(red_opid), 64'h0);

    // Basic exclusive walk, request in the first cycle out of reset
    cyc(); rst = 1'b0; head_opid = 15'd0; tail_opid = 15'd10; rb_ready = 1'b1;
    exe_req = 1'b1; exe_opid = 16'h8004; exe_npc = 64'h8000_1000;
    #1; idle("t1.accept");
    cyc(); #1; beat("t1.b0", 2'b11, 15'd9, 15'd8);
    cyc(); #1; beat("t1.b1", 2'b11, 15'd7, 15'd6);
    cyc(); #1; beat("t1.b2", 2'b01, 15'd5, 15'd0);
    cyc(); #1; redir("t1", 16'h8004, 64'h8000_1000);
    cyc(); #1; idle("t1.done");

    // Simultaneous requests: older exe beats younger com
    cyc(); tail_opid = 15'd5;
    com_req = 1'b1; com_opid = 16'h8003; com_npc = 64'hC0C0;
    exe_req = 1'b1; exe_opid = 16'h8001; exe_npc = 64'hE0E0;
    #1; idle("t2.accept");
    cyc(); #1; beat("t2.b0", 2'b11, 15'd4, 15'd3);
    cyc(); #1; beat("t2.b1", 2'b01, 15'd2, 15'd0);
    cyc(); #1; redir("t2", 16'h8001, 64'hE0E0);
    cyc(); #1; idle("t2.done");

    // Inclusive walk across the opid wrap point
    cyc(); head_opid = 15'h7FFE; tail_opid = 15'h0002;
    com_req = 1'b1; com_opid = 16'hFFFF; com_npc = 64'h100;
    #1; idle("t3.accept");
    cyc(); #1; beat("t3.b0", 2'b11, 15'h0001, 15'h0000);
    cyc(); #1; beat("t3.b1", 2'b01, 15'h7FFF, 15'h0);
    cyc(); #1; redir("t3", 16'hFFFF, 64'h100);
    cyc(); #1; idle("t3.done");

    // Stall for three cycles, then retarget older in the same cycle as a beat
    cyc(); head_opid = 15'd0; tail_opid = 15'd12; rb_ready = 1'b0;
    exe_req = 1'b1; exe_opid = 16'h8006; exe_npc = 64'hD00D;
    #1; idle("t4.accept");
    cyc(); #1; beat("t4.stall0", 2'b11, 15'd11, 15'd10);
    cyc(); #1; beat("t4.stall1", 2'b11, 15'd11, 15'd10);
    cyc(); #1; beat("t4.stall2", 2'b11, 15'd11, 15'd10);
    cyc(); rb_ready = 1'b1; exe_req = 1'b1; exe_opid = 16'h8002; exe_npc = 64'hE00E;
    #1; beat("t4.retgt", 2'b11, 15'd11, 15'd10);
    cyc(); exe_req = 1'b1; exe_opid = 16'h8005; exe_npc = 64'hBAD;
    #1; beat("t4.b1", 2'b11, 15'd9, 15'd8);
    cyc(); #1; beat("t4.b2", 2'b11, 15'd7, 15'd6);
    cyc(); #1; beat("t4.b3", 2'b11, 15'd5, 15'd4);
    cyc(); #1; beat("t4.b4", 2'b01, 15'd3, 15'd0);
    cyc(); #1; redir("t4", 16'h8002, 64'hE00E);
    cyc(); #1; idle("t4.done");

    // Nothing younger than target: straight to redirect; then ignored requests
    cyc(); tail_opid = 15'd10;
    exe_req = 1'b1; exe_opid = 16'h8009; exe_npc = 64'hF00;
    #1; idle("t5.accept");
    cyc(); #1; redir("t5", 16'h8009, 64'hF00);
    cyc(); exe_req = 1'b1; exe_opid = 16'h0004; exe_npc = 64'h1;
    #1; idle("t5.done");
    cyc(); exe_req = 1'b1; exe_opid = 16'h800A; exe_npc = 64'h2;
    #1; idle("t5.novalid");
    cyc(); com_req = 1'b1; com_opid = 16'h800C; com_npc = 64'h3;
    #1; idle("t5.tooyoung");
    cyc(); #1; idle("t5.ignored");
    chk("t5.red_opid_hold", 64'(red_opid), 64'h8009);
    chk("t5.red_npc_hold", red_npc, 64'hF00);

    // Older request during REDIR suppresses the pulse and restarts the walk
    cyc(); exe_req = 1'b1; exe_opid = 16'h8009; exe_npc = 64'hA1;
    #1; idle("t6.accept");
    cyc(); exe_req = 1'b1; exe_opid = 16'h8007; exe_npc = 64'hA2;
    #1;
    chk("t6.suppress.red_valid", 64'(red_valid), 64'(0));
    chk("t6.suppress.busy", 64'(busy), 64'(1));
    $display("redir-suppress t6 red_valid=%b", red_valid);
    cyc(); #1; beat("t6.b0", 2'b11, 15'd9, 15'd8);
    cyc(); #1; redir("t6", 16'h8007, 64'hA2);
    cyc(); #1; idle("t6.done");

    // Equal opid on both ports: com wins and is inclusive
    cyc(); tail_opid = 15'd8;
    com_req = 1'b1; com_opid = 16'h8004; com_npc = 64'hC4;
    exe_req = 1'b1; exe_opid = 16'h8004; exe_npc = 64'hE4;
    #1; idle("t7.accept");
    cyc(); #1; beat("t7.b0", 2'b11, 15'd7, 15'd6);
    cyc(); #1; beat("t7.b1", 2'b11, 15'd5, 15'd4);
    cyc(); #1; redir("t7", 16'h8004, 64'hC4);
    cyc(); #1; idle("t7.done");

    // Reset mid-walk aborts at once; fresh request replays the basic walk
    cyc(); tail_opid = 15'd10;
    exe_req = 1'b1; exe_opid = 16'h8004; exe_npc = 64'h8000_1000;
    #1; idle("t8.accept");
    cyc(); #1; beat("t8.b0", 2'b11, 15'd9, 15'd8);
    cyc(); rst = 1'b1;
    #1; idle("t8.rst");
    chk("t8.rst.red_npc", red_npc, 64'h0);
    chk("t8.rst.red_opid", 64'(red_opid), 64'h0);
    chk("t8.rst.lane0", 64'(rb_opid[0]), 64'h0);
    cyc(); rst = 1'b0;
    exe_req = 1'b1; exe_opid = 16'h8004; exe_npc = 64'h8000_1000;
    #1; idle("t8.reaccept");
    cyc(); #1; beat("t8.r0", 2'b11, 15'd9, 15'd8);
    cyc(); #1; beat("t8.r1", 2'b11, 15'd7, 15'd6);
    cyc(); #1; beat("t8.r2", 2'b01, 15'd5, 15'd0);
    cyc(); #1; redir("t8", 16'h8004, 64'h8000_1000);
    cyc(); #1; idle("t8.done");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
